gf_clmul_serial: RTL

//   Bit-serial carry-less (GF(2)[x]) polynomial multiplier; the producer side of the GF(2^m) reduction path.

---
 rtl/gf_clmul_serial_if.sv | 39 +++
 rtl/gf_clmul_serial.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/gf_clmul_serial_if.sv
// Handshake and data bundle for the bit-serial carry-less multiplier.
// Optional feature macro: GF_CLMUL_OPERAND_CHECK_EN (adds err_out).
interface gf_clmul_serial_if #(
   parameter int DATA_WIDTH = 10
);
   localparam int GW = $clog2(DATA_WIDTH) + 1;

   logic                      in_valid;
   logic                      in_ready;
   logic [GW-1:0]             polyn_grade;
   logic [DATA_WIDTH-1:0]     a_in;
   logic [DATA_WIDTH-1:0]     b_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [2*DATA_WIDTH-1:0]   prod_out;
   logic [GW-1:0]             grade_out;
   logic                      busy;
`ifdef GF_CLMUL_OPERAND_CHECK_EN
   logic                      err_out;
`endif

   // Producer of operands / consumer of products
   modport master (
      output in_valid, polyn_grade, a_in, b_in, out_ready,
      input  in_ready, out_valid, prod_out, grade_out, busy
`ifdef GF_CLMUL_OPERAND_CHECK_EN
      , input err_out
`endif
   );

   // The multiplier itself
   modport slave (
      input  in_valid, polyn_grade, a_in, b_in, out_ready,
      output in_ready, out_valid, prod_out, grade_out, busy
`ifdef GF_CLMUL_OPERAND_CHECK_EN
      , output err_out
`endif
   );
endinterface

// File: rtl/gf_clmul_serial.sv
// Bit-serial carry-less (GF(2)[x]) multiplier, MSB-first, one operand bit per
// cycle. Emits the unreduced product together with the captured field degree
// so the reduction stage can consume it directly.
// Optional feature macro: GF_CLMUL_OPERAND_CHECK_EN (registered operand check
// flag err_out, held with the product).
module gf_clmul_serial #(
   parameter int DATA_WIDTH = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   gf_clmul_serial_if.slave  bus
);
   localparam int GW = $clog2(DATA_WIDTH) + 1;
   localparam int PW = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   a_reg;
   logic [DATA_WIDTH-1:0]   b_reg;
   logic [PW-1:0]           acc;
   logic [GW-1:0]           count;
   logic [GW-1:0]           grade_reg;
   logic                    out_valid_r;
   logic                    busy_r;
   logic [DATA_WIDTH-1:0]   cap_mask;
   logic                    cap_grade_ok;
`ifdef GF_CLMUL_OPERAND_CHECK_EN
   logic                    err_r;
   logic                    cap_err;
`endif

   // Bits [g-1:0] set; saturates to all ones for g >= DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] grade_mask(input logic [GW-1:0] g);
      logic [DATA_WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (GW'(i) < g) m[i] = 1'b1;
      end
      return m;
   endfunction

   // Degrees below 2 or above DATA_WIDTH have no meaningful product.
   function automatic logic grade_valid(input logic [GW-1:0] g);
      return (g >= GW'(2)) && (g <= GW'(DATA_WIDTH));
   endfunction

   // One MSB-first shift-and-XOR step using operand bit B[cnt-1].
   function automatic logic [PW-1:0] clmul_step(
      input logic [PW-1:0]         acc_in,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b,
      input logic [GW-1:0]         cnt
   );
      logic [DATA_WIDTH-1:0] b_sh;
      logic [PW-1:0]         nxt;
      b_sh = b >> (cnt - 1'b1);
      nxt  = acc_in << 1;
      if (b_sh[0]) nxt = nxt ^ {{DATA_WIDTH{1'b0}}, a};
      return nxt;
   endfunction

   // Capture-side decode of the incoming degree
   assign cap_mask     = grade_mask(bus.polyn_grade);
   assign cap_grade_ok = grade_valid(bus.polyn_grade);
`ifdef GF_CLMUL_OPERAND_CHECK_EN
   assign cap_err = (|(bus.a_in & ~cap_mask)) | (|(bus.b_in & ~cap_mask)) | ~cap_grade_ok;
`endif

   // Control FSM plus operand/accumulator registers; degenerate degrees enter
   // RUN with count 0 so they fall straight through to DONE with acc = 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         acc         <= '0;
         count       <= '0;
         grade_reg   <= '0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
`ifdef GF_CLMUL_OPERAND_CHECK_EN
         err_r       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg     <= bus.a_in & cap_mask;
                  b_reg     <= bus.b_in & cap_mask;
                  grade_reg <= bus.polyn_grade;
                  acc       <= '0;
                  count     <= cap_grade_ok ? bus.polyn_grade : '0;
                  busy_r    <= 1'b1;
                  state     <= RUN;
`ifdef GF_CLMUL_OPERAND_CHECK_EN
                  err_r     <= cap_err;
`endif
               end
            end
            RUN: begin
               if (count == '0) begin
                  state       <= DONE;
                  out_valid_r <= 1'b1;
               end else begin
                  acc   <= clmul_step(acc, a_reg, b_reg, count);
                  count <= count - 1'b1;
                  if (count == GW'(1)) begin
                     state       <= DONE;
                     out_valid_r <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state       <= IDLE;
                  out_valid_r <= 1'b0;
                  busy_r      <= 1'b0;
`ifdef GF_CLMUL_OPERAND_CHECK_EN
                  err_r       <= 1'b0;
`endif
               end
            end
            default: begin
               state       <= IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Output drive: ready straight from state, everything else from registers
   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = out_valid_r;
   assign bus.busy      = busy_r;
   assign bus.prod_out  = acc;
   assign bus.grade_out = grade_reg;
`ifdef GF_CLMUL_OPERAND_CHECK_EN
   assign bus.err_out   = err_r;
`endif

endmodule
